// File: rtl/log_compact_pkg.sv
// Shared types and helpers for the log-compact to float decoder.
// Field widths of dec_t are sized for any practical WIDTH/LS.
package log_compact_pkg;

  localparam int DEC_EXP_W  = 16;
  localparam int DEC_FRAC_W = 16;

  localparam logic [31:0] QNAN_F32 = 32'h7FC0_0000;

  function automatic int posit_m(input int width, input int ls);
    return $clog2(width << ls) + 1;
  endfunction

  function automatic int posit_f(input int width, input int ls);
    return width - 3 - ls;
  endfunction

  function automatic int float_bias(input int exp);
    return (1 << (exp - 1)) - 1;
  endfunction

  typedef struct packed {
    logic                         sign;
    logic                         isZero;
    logic                         isNaR;
    logic signed [DEC_EXP_W-1:0]  signedExp;
    logic [DEC_FRAC_W-1:0]        frac;
  } dec_t;

endpackage

// File: rtl/log_frac_to_linear_rom.sv
// Registered 2^f - 1 table; entries built at elaboration in fixed point.
// Bit L of the data word is the round-up carry into the exponent.
module log_frac_to_linear_rom #(
  parameter int F = 4,
  parameter int L = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_en,
  input  logic [F-1:0] i_addr,
  output logic [L:0]   o_data
);

  localparam int Q = 30;

  // 2^(a/2^F) as a product of repeated square roots of 2, then RNE
  function automatic logic [L:0] lin(input int a);
    longint unsigned x, r, v, q, rem, half, t, res;
    x = 64'd1 << Q;
    r = 64'd2 << Q;
    for (int lv = 1; lv <= F; lv++) begin
      res = 64'd0;
      for (int b = 31; b >= 0; b--) begin
        t = res | (64'd1 << b);
        if (t * t <= (r << Q)) res = t;
      end
      r = res;
      if (((a >> (F - lv)) & 1) != 0) x = (x * r) >> Q;
    end
    v    = (x - (64'd1 << Q)) << L;
    q    = v >> Q;
    rem  = v & ((64'd1 << Q) - 64'd1);
    half = 64'd1 << (Q - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    return (L+1)'(q);
  endfunction

  logic [L:0] w_tab [2**F];

  for (genvar g = 0; g < 2**F; g++) begin : g_tab
    localparam logic [L:0] V = lin(g);
    assign w_tab[g] = V;
  end

  logic [L:0] r_data;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_data <= '0;
    else if (i_en) r_data <= w_tab[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/log_compact_to_float_stream.sv
// 3-stage streaming decoder: log-compact word in, IEEE-style float out.
// Define LOG_COMPACT_DECODE_STATS_EN for zero/NaR output counters.
module log_compact_to_float_stream
  import log_compact_pkg::*;
#(
  parameter int WIDTH              = 8,
  parameter int LS                 = 1,
  parameter int LOG_TO_LINEAR_BITS = 8,
  parameter int EXP                = 8,
  parameter int FRAC               = 23
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                inValid,
  output logic                inReady,
  input  logic [WIDTH-1:0]    inData,
  output logic                outValid,
  input  logic                outReady,
  output logic [EXP+FRAC:0]   outData,
  output logic                outIsSpecial
`ifdef LOG_COMPACT_DECODE_STATS_EN
  ,
  output logic [31:0]         statZeros,
  output logic [31:0]         statNaRs
`endif
);

  localparam int N    = WIDTH - 1;
  localparam int PF   = posit_f(WIDTH, LS);
  localparam int L    = LOG_TO_LINEAR_BITS;
  localparam int OW   = 1 + EXP + FRAC;
  localparam int BIAS = float_bias(EXP);
  localparam logic [OW-1:0] W_NAN =
    (EXP == 8 && FRAC == 23) ? OW'(QNAN_F32)
    : {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};

  logic r_live;
  logic r_s1_valid, r_s2_valid, r_s3_valid;
  logic w_s1_load, w_s2_load, w_s3_load;
  dec_t w_dec, r_s1;
  logic r_s2_sign, r_s2_zero, r_s2_nar;
  logic signed [DEC_EXP_W-1:0] r_s2_exp;
  logic [PF-1:0] w_rom_addr;
  logic [L:0] w_rom;
  logic signed [31:0] w_bexp;
  logic [L-1:0] w_mant;
  logic [OW-1:0] w_pack, r_out;
  logic r_out_special;

  assign w_s3_load = r_s2_valid && (!r_s3_valid || outReady);
  assign w_s2_load = r_s1_valid && (!r_s2_valid || w_s3_load);
  assign inReady   = r_live && (!r_s1_valid || w_s2_load);
  assign w_s1_load = inValid && inReady;

  // Regime run length, then exponent and fraction bits left-aligned
  always_comb begin
    int run;
    int k;
    logic lead;
    logic stop;
    logic [LS+PF-1:0] ef;
    lead = inData[N-1];
    run  = 0;
    stop = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!stop && inData[i] == lead) run++;
      else stop = 1'b1;
    end
    k  = lead ? run - 1 : -run;
    ef = (LS+PF)'((inData[N-1:0] << (run + 1)) >> 2);
    w_dec           = '0;
    w_dec.sign      = inData[N];
    w_dec.isZero    = (inData[N-1:0] == '0) && !inData[N];
    w_dec.isNaR     = (inData[N-1:0] == '0) && inData[N];
    w_dec.signedExp = DEC_EXP_W'(k * (1 << LS) + int'(ef[PF +: LS]));
    w_dec.frac      = DEC_FRAC_W'(ef[PF-1:0]) << (DEC_FRAC_W - PF);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_live     <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (inReady) r_s1_valid <= inValid;
      if (!r_s2_valid || w_s3_load) r_s2_valid <= r_s1_valid;
      if (!r_s3_valid || outReady) r_s3_valid <= r_s2_valid;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s1          <= '0;
      r_s2_sign     <= 1'b0;
      r_s2_zero     <= 1'b0;
      r_s2_nar      <= 1'b0;
      r_s2_exp      <= '0;
      r_out         <= '0;
      r_out_special <= 1'b0;
    end else begin
      if (w_s1_load) r_s1 <= w_dec;
      if (w_s2_load) begin
        r_s2_sign <= r_s1.sign;
        r_s2_zero <= r_s1.isZero;
        r_s2_nar  <= r_s1.isNaR;
        r_s2_exp  <= r_s1.signedExp;
      end
      if (w_s3_load) begin
        r_out         <= w_pack;
        r_out_special <= r_s2_zero || r_s2_nar;
      end
    end
  end

  assign w_rom_addr = PF'(r_s1.frac >> (DEC_FRAC_W - PF));

  log_frac_to_linear_rom #(
    .F (PF),
    .L (L)
  ) u_rom (
    .clock  (clock),
    .resetn (resetn),
    .i_en   (w_s2_load),
    .i_addr (w_rom_addr),
    .o_data (w_rom)
  );

  always_comb begin
    w_bexp = 32'(r_s2_exp) + 32'(w_rom[L]) + BIAS;
    w_mant = w_rom[L] ? '0 : w_rom[L-1:0];
    if (r_s2_nar)
      w_pack = W_NAN;
    else if (r_s2_zero)
      w_pack = '0;
    else if (w_bexp <= 0)
      w_pack = {r_s2_sign, {(EXP+FRAC){1'b0}}};
    else if (w_bexp >= (1 << EXP) - 1)
      w_pack = {r_s2_sign, {EXP{1'b1}}, {FRAC{1'b0}}};
    else
      w_pack = {r_s2_sign, w_bexp[EXP-1:0], w_mant, {(FRAC-L){1'b0}}};
  end

  assign outValid     = r_s3_valid;
  assign outData      = r_out;
  assign outIsSpecial = r_out_special;

`ifdef LOG_COMPACT_DECODE_STATS_EN
  logic r_s3_zero, r_s3_nar;
  logic [31:0] r_stat_zeros, r_stat_nars;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s3_zero    <= 1'b0;
      r_s3_nar     <= 1'b0;
      r_stat_zeros <= '0;
      r_stat_nars  <= '0;
    end else begin
      if (w_s3_load) begin
        r_s3_zero <= r_s2_zero;
        r_s3_nar  <= r_s2_nar;
      end
      if (r_s3_valid && outReady) begin
        if (r_s3_zero && r_stat_zeros != '1)
          r_stat_zeros <= r_stat_zeros + 32'd1;
        if (r_s3_nar && r_stat_nars != '1)
          r_stat_nars <= r_stat_nars + 32'd1;
      end
    end
  end

  assign statZeros = r_stat_zeros;
  assign statNaRs  = r_stat_nars;
`endif

endmodule

// File: tb/tb_log_compact_to_float_stream.sv
// Scoreboard bench for log_compact_to_float_stream.
// Expected words are queued at accept time and compared on output.
module tb_log_compact_to_float_stream;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  inData = 8'h00;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] outData;
  logic        outIsSpecial;
`ifdef LOG_COMPACT_DECODE_STATS_EN
  logic [31:0] statZeros, statNaRs;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  bit lat_en = 1'b0;
  bit rnd_on = 1'b0;
  logic [31:0] snap;

  typedef struct {
    logic [31:0] d;
    logic        sp;
    int          c;
    bit          lat;
  } exp_t;

  exp_t sb[$];

  log_compact_to_float_stream dut (
    .clock        (clock),
    .resetn       (resetn),
    .inValid      (inValid),
    .inReady      (inReady),
    .inData       (inData),
    .outValid     (outValid),
    .outReady     (outReady),
    .outData      (outData),
    .outIsSpecial (outIsSpecial)
`ifdef LOG_COMPACT_DECODE_STATS_EN
    ,
    .statZeros    (statZeros),
    .statNaRs     (statNaRs)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // Bit-serial walk of the word; returns {special, float}
  function automatic logic [32:0] model(input logic [7:0] w);
    int pos, run, k, e, f, ex, mi;
    logic lead;
    real m;
    if (w[6:0] == 7'd0)
      return w[7] ? {1'b1, 32'h7FC0_0000} : {1'b1, 32'h0};
    lead = w[6];
    pos  = 6;
    run  = 0;
    while (pos >= 0 && w[pos] == lead) begin
      run++;
      pos--;
    end
    pos--;
    k = lead ? run - 1 : -run;
    e = 0;
    if (pos >= 0) begin
      e = int'(w[pos]);
      pos--;
    end
    f = 0;
    for (int j = 0; j < 4; j++) begin
      f = f * 2;
      if (pos >= 0) begin
        f += int'(w[pos]);
        pos--;
      end
    end
    ex = 2 * k + e + 127;
    m  = (2.0 ** (f / 16.0) - 1.0) * 256.0;
    mi = $rtoi(m + 0.5);
    if (mi >= 256) begin
      mi = 0;
      ex++;
    end
    return {1'b0, w[7], 8'(ex), 8'(mi), 15'd0};
  endfunction

  task automatic send(input logic [7:0] w, input logic [31:0] e,
                      input logic sp);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    inValid = 1'b1;
    inData  = w;
    while (!acc) begin
      @(negedge clock);
      if (inReady) begin
        acc = 1'b1;
        sb.push_back('{e, sp, cyc, lat_en});
      end
      @(posedge clock);
      #1;
      n++;
      if (!acc && n > 300) begin
        chk("accept_timeout", 64'(n), 64'd0);
        acc = 1'b1;
      end
    end
    inValid = 1'b0;
  endtask

  task automatic send_m(input logic [7:0] w);
    logic [32:0] r;
    r = model(w);
    send(w, r[31:0], r[32]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clock);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (resetn && outValid && outReady) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(outData), 64'(e.d));
        chk("out_special", 64'(outIsSpecial), 64'(e.sp));
        if (e.lat) chk("latency", 64'(cyc - e.c), 64'd3);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_outData", 64'(outData), 64'd0);
    chk("rst_special", 64'(outIsSpecial), 64'd0);
    chk("rst_inReady", 64'(inReady), 64'd0);
    resetn = 1'b1;
    #1;
    chk("inReady_pre", 64'(inReady), 64'd0);
    @(posedge clock);
    #1;
    chk("inReady_post", 64'(inReady), 64'd1);

    lat_en = 1'b1;
    send(8'h40, 32'h3F80_0000, 1'b0);
    send(8'h50, 32'h4000_0000, 1'b0);
    send(8'h60, 32'h4080_0000, 1'b0);
    send(8'h30, 32'h3F00_0000, 1'b0);
    send(8'hC0, 32'hBF80_0000, 1'b0);
    send(8'h48, 32'h3FB5_0000, 1'b0);
    send(8'h00, 32'h0000_0000, 1'b1);
    send(8'h80, 32'h7FC0_0000, 1'b1);
    drain();
`ifdef LOG_COMPACT_DECODE_STATS_EN
    chk("stat_zeros", 64'(statZeros), 64'd1);
    chk("stat_nars", 64'(statNaRs), 64'd1);
`endif
    for (int i = 0; i < 24; i++) send_m(8'($urandom));
    drain();
    lat_en = 1'b0;

    fork
      begin
        for (int i = 0; i < 8; i++) send_m(8'h20 + 8'(i * 13));
      end
      begin
        repeat (4) @(posedge clock);
        #1;
        outReady = 1'b0;
        @(negedge clock);
        snap = outData;
        chk("stall_valid", 64'(outValid), 64'd1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          chk("stall_stable", 64'(outData), 64'(snap));
        end
        chk("stall_inReady", 64'(inReady), 64'd0);
        @(posedge clock);
        #1;
        outReady = 1'b1;
      end
    join
    drain();

    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clock);
          #1;
          outReady = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 40; i++) send_m(8'($urandom));
    drain();
    rnd_on = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    outReady = 1'b1;

    outReady = 1'b0;
    send_m(8'h40);
    send_m(8'h50);
    repeat (2) @(posedge clock);
    #1;
    chk("pre_rst_valid", 64'(outValid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(outValid), 64'd0);
    sb.delete();
    @(posedge clock);
    #1;
    resetn   = 1'b1;
    outReady = 1'b1;
    n_out    = 0;
`ifdef LOG_COMPACT_DECODE_STATS_EN
    chk("stat_zeros_rst", 64'(statZeros), 64'd0);
`endif
    @(posedge clock);
    #1;
    send(8'h40, 32'h3F80_0000, 1'b0);
    drain();
    repeat (5) @(posedge clock);
    chk("post_rst_count", 64'(n_out), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/log_compact_to_float_stream.md
Name: log_compact_to_float_stream

Overview:
- Streaming decoder: tapered log-posit words (LogNumberCompact, WIDTH/LS) in, IEEE-style Float (EXP/FRAC) words out.
- Inverse of the float→log-compact encode path.
- 3-stage pipeline with valid/ready backpressure; sits between log-domain accumulator/storage and float consumers/debug dumps.
- Replaces the combinational LogCompactToLogUnpacked + LogToFloat chain where timing or streaming is required.

Parameters:
- WIDTH, 8, log-compact word width incl. sign
- LS, 1, log-scale (exponent) bits after regime
- LOG_TO_LINEAR_BITS, 8, fraction bits produced by 2^f lookup
- EXP, 8, output float exponent bits
- FRAC, 23, output float fraction bits

Ports:
- clock  in  1  clock
- resetn  in  1  async active-low reset
- inValid  in  1  input word valid
- inReady  out  1  block accepts input this cycle
- inData  in  WIDTH  log-compact word
- outValid  out  1  output word valid
- outReady  in  1  downstream accepts output
- outData  out  1+EXP+FRAC  float {sign, exp, frac}
- outIsSpecial  out  1  output came from zero or NaR input

Behaviour:
- Interface: one clock `clock`; reset `resetn` is asynchronous, active-low.
- Reset: all stage valids 0 → outValid=0; outData=0, outIsSpecial=0. inReady=1 one cycle after reset deassertion.
- Handshake: transfer on valid&&ready. inValid may not drop and inData may not change while inValid=1 and inReady=0. outValid/outData are held stable while outValid=1 and outReady=0.
- Pipeline: S1 decode, S2 lookup, S3 pack.
  - Each stage advances when its successor is empty or advancing.
  - inReady = !s1Valid || s1Advance; fully combinational backpressure chain.
  - Latency: exactly 3 cycles input-accept → outValid with no stall. Throughput 1/cycle.
- S1 decode:
  - MSB = sign; remaining WIDTH-1 bits = magnitude (sign-magnitude).
  - Regime run length gives k; the next LS bits give e.
  - Remaining bits are fraction f, left-aligned and zero-padded to POSIT_F bits.
  - Signed log exponent = k·2^LS + e.
  - Magnitude all-zero: sign=0 → zero, sign=1 → NaR.
- S2 lookup: linear mantissa m = round-to-nearest-even(2^(f/2^POSIT_F) − 1) to LOG_TO_LINEAR_BITS bits. If m rounds to 2^LOG_TO_LINEAR_BITS, exponent += 1 and m = 0.
- S3 pack:
  - exp field = logExp + bias (2^(EXP−1)−1); frac = m << (FRAC−LOG_TO_LINEAR_BITS).
  - biased exp ≤ 0 → signed zero; ≥ all-ones → infinity with sign. Not reachable at the defaults; required for generality.
  - Zero → 0x00000000. NaR → quiet NaN 0x7FC00000. outIsSpecial=1 for both.
- Reset mid-stream: in-flight words discarded, no partial output.
- Simultaneous: S3 drain plus S1 fill in the same cycle is allowed; no bubble.

Optional Feature:
- Macro LOG_COMPACT_DECODE_STATS_EN.
- Defined:
  - Adds output ports statZeros[31:0] and statNaRs[31:0], reset to 0.
  - Each increments on an output handshake of the corresponding special value.
  - Saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package log_compact_pkg:
  - POSIT_M/POSIT_F derivation functions (signed exponent bits, fraction bits from WIDTH/LS).
  - Float bias constant.
  - Decoded-word struct {sign, isZero, isNaR, signedExp, frac}.
  - NaN constant.
- Sub-module log_frac_to_linear_rom: synchronous-read 2^f table, POSIT_F-bit address, LOG_TO_LINEAR_BITS+1-bit data incl. carry, with a read-enable tied to the S2 advance. Its register is S2.

Test Plan:
- 0x40 → 0x3F800000 (1.0); 0x50 → 0x40000000; 0x60 → 0x40800000; 0x30 → 0x3F000000; each 3 cycles after accept.
- 0xC0 → 0xBF800000; 0x48 → 0x3FB50000 (√2, m=0x6A).
- 0x00 → 0x00000000 and 0x80 → 0x7FC00000, outIsSpecial=1. With stats enabled, statZeros=1 and statNaRs=1.
- Back-to-back burst 0x40,0x50,0x60,0x30 with outReady=1 → outputs on consecutive cycles, in order.
- outReady=0 for 5 cycles mid-burst:
  - inReady drops after 3 words are held.
  - outData is stable while stalled.
  - No loss or duplication after release.
- resetn pulsed low with 2 words in flight → outValid=0 immediately (async). Next input 0x40 yields only 0x3F800000.
